// File: rtl/nlms_weight_update.sv
// Serial NLMS coefficient-update engine.
// One tap per clock: a registered product e*x_k feeds a saturating
// accumulate into the coefficient register file on the following edge.
module nlms_weight_update #(
   parameter int TAPS       = 32,
   parameter int XW         = 14,
   parameter int WW         = 32,
   parameter int GAIN_SHIFT = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 update_start,
   input  logic                 weight_clr,
   input  logic [XW-1:0]        e,
   input  logic [4:0]           mu_shift,
   input  logic [TAPS*XW-1:0]   buffer_flat,
   output logic [TAPS*WW-1:0]   weight_flat,
   output logic                 busy,
   output logic                 done
);

   localparam int IW = $clog2(TAPS + 1);   // tap index counts 0..TAPS
   localparam int PW = 2 * XW + 1;         // signed e times zero-extended x
   localparam int DW = 48;                 // delta width
   localparam int SW = DW + 1;             // accumulate width before saturation
   localparam logic [IW-1:0] LAST_IDX = IW'(TAPS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // w + delta, clamped to the coefficient range instead of wrapping
   function automatic logic [WW-1:0] sat_add(input logic [WW-1:0] w, input logic [DW-1:0] d);
      logic [SW-1:0] s;
      s = {{(SW-WW){w[WW-1]}}, w} + {d[DW-1], d};
      if (s[SW-1:WW-1] == {(SW-WW+1){s[SW-1]}}) begin
         sat_add = s[WW-1:0];
      end else if (s[SW-1]) begin
         sat_add = {1'b1, {(WW-1){1'b0}}};
      end else begin
         sat_add = {1'b0, {(WW-1){1'b1}}};
      end
   endfunction

   state_t               state_r, state_nxt_s;
   logic [IW-1:0]        idx_r;
   logic [XW-1:0]        e_lat_r;
   logic [4:0]           mu_lat_r;
   logic signed [PW-1:0] prod_r;
   logic [WW-1:0]        w_r [TAPS];
   logic                 busy_r, done_r;

   logic [IW-1:0]        wr_idx_s;
   logic [XW-1:0]        x_s;
   logic [WW-1:0]        w_sel_s;
   logic signed [PW-1:0] e_ext_s, x_ext_s;
   logic signed [DW-1:0] prod_ext_s, shl_s, delta_s;
   logic [WW-1:0]        sum_s;
   logic                 ld_s, mul_en_s, wr_en_s;

   // Next-state logic; a clear always forces the FSM home
   always_comb begin
      state_nxt_s = state_r;
      if (weight_clr) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:   state_nxt_s = update_start ? ST_UPDATE : ST_IDLE;
            ST_UPDATE: state_nxt_s = (idx_r == LAST_IDX) ? ST_DONE : ST_UPDATE;
            ST_DONE:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Pass control strobes and the tap operand / write-target muxes
   always_comb begin
      ld_s     = (state_r == ST_IDLE) && update_start && !weight_clr;
      mul_en_s = (state_r == ST_UPDATE) && (idx_r < LAST_IDX);
      wr_en_s  = (state_r == ST_UPDATE) && (idx_r != {IW{1'b0}});
      wr_idx_s = idx_r - {{(IW-1){1'b0}}, 1'b1};
      x_s      = {XW{1'b0}};
      w_sel_s  = {WW{1'b0}};
      for (int k = 0; k < TAPS; k++) begin
         x_s     = x_s | ({XW{idx_r == IW'(k)}} & buffer_flat[k*XW +: XW]);
         w_sel_s = w_sel_s | ({WW{wr_idx_s == IW'(k)}} & w_r[k]);
      end
   end

   // Product operands, gain/step-size shift (arithmetic, floors) and saturated sum
   always_comb begin
      e_ext_s    = {{(PW-XW){e_lat_r[XW-1]}}, e_lat_r};
      x_ext_s    = {{(PW-XW){1'b0}}, x_s};
      prod_ext_s = {{(DW-PW){prod_r[PW-1]}}, prod_r};
      shl_s      = prod_ext_s <<< GAIN_SHIFT;
      delta_s    = shl_s >>> mu_lat_r;
      sum_s      = sat_add(w_sel_s, delta_s);
   end

   // State register with registered busy/done decoded from the next state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == ST_UPDATE);
         done_r  <= (state_nxt_s == ST_DONE);
      end
   end

   // Operand latches, tap index and product pipeline register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_r    <= {IW{1'b0}};
         e_lat_r  <= {XW{1'b0}};
         mu_lat_r <= 5'd0;
         prod_r   <= {PW{1'b0}};
      end else if (weight_clr) begin
         idx_r    <= {IW{1'b0}};
         prod_r   <= {PW{1'b0}};
      end else if (ld_s) begin
         idx_r    <= {IW{1'b0}};
         e_lat_r  <= e;
         mu_lat_r <= mu_shift;
      end else if (mul_en_s) begin
         idx_r    <= idx_r + {{(IW-1){1'b0}}, 1'b1};
         prod_r   <= e_ext_s * x_ext_s;
      end else begin
         idx_r    <= idx_r;
      end
   end

   // Coefficient file: only the tap being written changes on any edge
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < TAPS; k++) w_r[k] <= {WW{1'b0}};
      end else if (weight_clr) begin
         for (int k = 0; k < TAPS; k++) w_r[k] <= {WW{1'b0}};
      end else if (wr_en_s) begin
         for (int k = 0; k < TAPS; k++) begin
            if (wr_idx_s == IW'(k)) begin
               w_r[k] <= sum_s;
            end else begin
               w_r[k] <= w_r[k];
            end
         end
      end else begin
         for (int k = 0; k < TAPS; k++) w_r[k] <= w_r[k];
      end
   end

   for (genvar g = 0; g < TAPS; g++) begin : g_flat
      assign weight_flat[g*WW +: WW] = w_r[g];
   end

   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_nlms_weight_update.sv
// Self-checking bench for nlms_weight_update: directed and randomized passes
// compared against an arithmetic reference of the coefficient update.
module tb_nlms_weight_update;

   localparam int TAPS = 32;
   localparam int XW   = 14;
   localparam int WW   = 32;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 update_start;
   logic                 weight_clr;
   logic [XW-1:0]        e;
   logic [4:0]           mu_shift;
   logic [TAPS*XW-1:0]   buffer_flat;
   logic [TAPS*WW-1:0]   weight_flat;
   logic                 busy;
   logic                 done;

   nlms_weight_update dut (
      .clk          (clk),
      .rstn         (rstn),
      .update_start (update_start),
      .weight_clr   (weight_clr),
      .e            (e),
      .mu_shift     (mu_shift),
      .buffer_flat  (buffer_flat),
      .weight_flat  (weight_flat),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int                 checks = 0;
   int                 errors = 0;
   longint             mw [TAPS];
   logic [TAPS*XW-1:0] bufv;
   int                 busy_cnt, done_cnt, done_at;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: w_k += floor(e*x_k*256 / 2^mu), clamped to 32-bit signed
   task automatic model_pass(input logic [XW-1:0] ev, input logic [4:0] mu);
      longint p, d, s;
      for (int k = 0; k < TAPS; k++) begin
         p = longint'($signed(ev)) * longint'(bufv[k*XW +: XW]);
         d = (p * 64'sd256) >>> mu;
         s = mw[k] + d;
         if (s > 64'sd2147483647) s = 64'sd2147483647;
         if (s < -64'sd2147483648) s = -64'sd2147483648;
         mw[k] = s;
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < TAPS; k++) mw[k] = 64'sd0;
   endtask

   task automatic chk_weights(input string tag);
      logic [31:0] ew;
      for (int k = 0; k < TAPS; k++) begin
         ew = 32'(mw[k]);
         chk($sformatf("%s_w%0d", tag, k), {32'd0, weight_flat[k*WW +: WW]}, {32'd0, ew});
      end
   endtask

   task automatic fill_buf_rand();
      for (int k = 0; k < TAPS; k++) bufv[k*XW +: XW] = 14'($urandom);
   endtask

   task automatic fill_buf_const(input logic [XW-1:0] v);
      for (int k = 0; k < TAPS; k++) bufv[k*XW +: XW] = v;
   endtask

   // One pass from a start pulse; optional restart/clear/operand-change events at T+n
   task automatic run_pass(input logic [XW-1:0] ev, input logic [4:0] mu,
                           input int restart_at, input int clr_at,
                           input int echg_at, input logic [XW-1:0] e_new);
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = 0;
      @(negedge clk);
      e            = ev;
      mu_shift     = mu;
      buffer_flat  = bufv;
      update_start = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         update_start = 1'b0;
         weight_clr   = 1'b0;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            done_at = i;
         end
         if (i == restart_at) update_start = 1'b1;
         if (i == clr_at) weight_clr = 1'b1;
         if (i == echg_at) begin
            e        = e_new;
            mu_shift = ~mu;
         end
      end
   endtask

   task automatic chk_timing(input string tag);
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
      chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      chk({tag, "_done_cycle"}, 64'(done_at), 64'd34);
   endtask

   task automatic clear_weights();
      @(negedge clk);
      weight_clr = 1'b1;
      @(negedge clk);
      weight_clr = 1'b0;
      model_clear();
   endtask

   initial begin
      logic [XW-1:0] ev, ev2;
      logic [4:0]    mu;

      rstn         = 1'b0;
      update_start = 1'b0;
      weight_clr   = 1'b0;
      e            = 14'd0;
      mu_shift     = 5'd0;
      buffer_flat  = '0;
      bufv         = '0;
      model_clear();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (5) @(negedge clk);

      // Reset state
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk_weights("rst");

      // Ramp: e=1, x_k=k, mu=0 gives w_k = 256*k
      for (int k = 0; k < TAPS; k++) bufv[k*XW +: XW] = 14'(k);
      run_pass(14'd1, 5'd0, 0, 0, 0, 14'd0);
      model_pass(14'd1, 5'd0);
      chk_timing("ramp");
      chk("ramp_w31_abs", {32'd0, weight_flat[31*WW +: WW]}, 64'd7936);
      chk_weights("ramp");

      // Floor behaviour of the step-size shift
      clear_weights();
      fill_buf_const(14'd100);
      run_pass(14'h3FFE, 5'd3, 0, 0, 0, 14'd0);
      model_pass(14'h3FFE, 5'd3);
      chk("round1_w0_abs", {32'd0, weight_flat[0 +: WW]}, {32'd0, 32'hFFFF_E700});
      fill_buf_const(14'd1);
      run_pass(14'h3FFF, 5'd9, 0, 0, 0, 14'd0);
      model_pass(14'h3FFF, 5'd9);
      chk("round2_w0_abs", {32'd0, weight_flat[0 +: WW]}, {32'd0, 32'hFFFF_E6FF});
      chk_weights("round2");

      // Saturation at both rails
      clear_weights();
      fill_buf_const(14'd16383);
      for (int p = 0; p < 3; p++) begin
         run_pass(14'h1FFF, 5'd0, 0, 0, 0, 14'd0);
         model_pass(14'h1FFF, 5'd0);
         chk($sformatf("satp%0d_w5_abs", p), {32'd0, weight_flat[5*WW +: WW]}, {32'd0, 32'h7FFF_FFFF});
      end
      chk_weights("satp");
      for (int p = 0; p < 2; p++) begin
         run_pass(14'h2000, 5'd0, 0, 0, 0, 14'd0);
         model_pass(14'h2000, 5'd0);
      end
      chk("satn_w9_abs", {32'd0, weight_flat[9*WW +: WW]}, {32'd0, 32'h8000_0000});
      chk_weights("satn");

      // Restart while busy is ignored
      clear_weights();
      fill_buf_rand();
      ev = 14'($urandom);
      mu = 5'($urandom_range(0, 12));
      run_pass(ev, mu, 5, 0, 0, 14'd0);
      model_pass(ev, mu);
      chk_timing("restart");
      chk_weights("restart");

      // Clear mid-pass: no done pulse, everything zero
      fill_buf_rand();
      run_pass(14'($urandom), 5'd2, 0, 10, 0, 14'd0);
      model_clear();
      chk("clrmid_done_count", 64'(done_cnt), 64'd0);
      chk("clrmid_busy_cycles", 64'(busy_cnt), 64'd10);
      chk("clrmid_busy", {63'd0, busy}, 64'd0);
      chk_weights("clrmid");

      // Clear and start together: clear wins
      @(negedge clk);
      update_start = 1'b1;
      weight_clr   = 1'b1;
      @(negedge clk);
      update_start = 1'b0;
      weight_clr   = 1'b0;
      chk("clrstart_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      chk("clrstart_busy2", {63'd0, busy}, 64'd0);
      chk_weights("clrstart");

      // Operand change after start has no effect
      fill_buf_rand();
      ev  = 14'($urandom);
      ev2 = ~ev;
      mu  = 5'($urandom_range(0, 10));
      run_pass(ev, mu, 0, 0, 3, ev2);
      model_pass(ev, mu);
      chk_timing("echg");
      chk_weights("echg");

      // Random accumulation passes
      for (int r = 0; r < 6; r++) begin
         fill_buf_rand();
         ev = 14'($urandom);
         mu = 5'($urandom);
         run_pass(ev, mu, 0, 0, 0, 14'd0);
         model_pass(ev, mu);
         chk_timing($sformatf("rnd%0d", r));
         chk_weights($sformatf("rnd%0d", r));
      end

      // Zero error, zero shift: weights unchanged, done still pulses
      fill_buf_rand();
      run_pass(14'd0, 5'd0, 0, 0, 0, 14'd0);
      model_pass(14'd0, 5'd0);
      chk_timing("zero");
      chk_weights("zero");

      // Asynchronous reset mid-pass, observed before any clock edge
      fill_buf_rand();
      @(negedge clk);
      e            = 14'd1000;
      mu_shift     = 5'd0;
      buffer_flat  = bufv;
      update_start = 1'b1;
      @(negedge clk);
      update_start = 1'b0;
      repeat (14) @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      model_clear();
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_done", {63'd0, done}, 64'd0);
      chk_weights("arst");
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("arst_idle_busy", {63'd0, busy}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
